ov7670_stream_source: RTL
=========================

# ov7670_stream_source

Synthetic OV7670 pixel-stream transmitter: generates the camera-side vsync/href/data waveform that the integral-image capture path receives, carrying a selectable luma test pattern. Used as an in-fabric stand-in for the sensor in place of the physical `ov7670_*` inputs, enabling closed-loop bring-up and regression of capture, buffer and cascade without a camera. Runs entirely in the pixel-clock domain and emits one byte per clock.

## Interface
Parameters:
- H_ACTIVE, 160, active pixels per line (2 bytes each).
- V_ACTIVE, 120, active lines per frame.
- H_BLANK, 16, href-low cycles after each active line's bytes.
- VSYNC_LINES, 3, lines with vsync high.
- V_BACK, 17, blank lines after vsync.
- V_FRONT, 10, blank lines after last active line.

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request one frame; sampled only in IDLE.
- continuous  in  1  while high, frames repeat back-to-back.
- pattern_sel  in  2  pattern, latched at frame start.
- ov_vsync  out  1  frame sync, active high.
- ov_href  out  1  byte-valid line qualifier.
- ov_data  out  8  stream byte; 0 whenever href low.
- busy  out  1  high from frame start through the last front-porch cycle.
- frame_done  out  1  one-cycle pulse at frame end.
- frame_sum  out  16  byte checksum of last completed frame (see Configuration).

## Operation
- LINE_LEN = 2*H_ACTIVE + H_BLANK cycles. Frame length = (VSYNC_LINES+V_BACK+V_ACTIVE+V_FRONT)*LINE_LEN cycles.
- States: IDLE, VSYNC, VBACK, ACTIVE, VFRONT. Column counter col (0..LINE_LEN-1) and line counter sweep each state.
- IDLE -> VSYNC when start|continuous sampled high. VSYNC -> VBACK after VSYNC_LINES lines; VBACK -> ACTIVE after V_BACK lines; ACTIVE -> VFRONT after V_ACTIVE lines; VFRONT -> VSYNC if continuous high on the final VFRONT cycle, else IDLE.
- VSYNC: ov_vsync=1, href=0. VBACK/VFRONT: both 0. ACTIVE: href=1 for col < 2*H_ACTIVE, else 0.
- Pixel x=col>>1, y=active line index. Byte order: col even -> luma L(x,y); col odd -> 8'h80.
- Patterns: 0 flat L=8'h80; 1 horizontal ramp L=x[7:0]; 2 8x8 checkerboard L=(x[3]^y[3])?8'hFF:8'h00; 3 vertical ramp L=y[7:0].
- pattern_sel and continuous changes mid-frame never alter the frame in progress (continuous is only examined at frame end).
- start while busy: ignored.

## Timing
- Reset: state IDLE, counters 0, all outputs 0 (vsync, href, data, busy, frame_done, frame_sum) on the cycle after rst_n sampled low; reset mid-frame aborts immediately, no frame_done.
- start sampled high at edge n -> ov_vsync and busy high from cycle n+1 (registered outputs, 1-cycle latency).
- First href-high byte appears (VSYNC_LINES+V_BACK)*LINE_LEN cycles after vsync rise.
- frame_done high during the cycle after the last VFRONT cycle; busy low that same cycle unless restarting, in which case vsync rises that cycle too (no gap between frames).
- Counters wrap only at their parameter limits; line counters reset to 0 at every state change.

## Configuration
- OV_STREAM_CHECKSUM_EN defined: 16-bit accumulator adds every byte with href high (mod 2^16), cleared at frame start, copied to frame_sum at frame_done.
- Undefined: accumulator omitted, frame_sum tied to 16'h0000. Port list identical either way.

## Test plan
Bench params H_ACTIVE=4, V_ACTIVE=2, H_BLANK=2, VSYNC_LINES=1, V_BACK=1, V_FRONT=1 (LINE_LEN=10, frame 50 cycles).
- Reset: hold rst_n=0 with start=1 -> all outputs 0, no vsync; release -> vsync rises 1 cycle later.
- Single frame, pattern 1: start pulse -> vsync high 10 cycles, href low 10, then per line data 00,80,01,80,02,80,03,80,0,0; frame_done at cycle 51, busy low after.
- Pattern 2 with H_ACTIVE=16: line 0 luma FF for x=8..15, 00 for x=0..7 -> verified byte-exact.
- Continuous high, dropped mid-second frame -> exactly two frames, vsync of frame 2 rises on frame 1's frame_done cycle, IDLE after frame 2.
- rst_n low at cycle 25 of a frame -> outputs 0 next cycle, no frame_done; new start gives a full clean frame.
- OV_STREAM_CHECKSUM_EN, pattern 0: frame_sum = 16 bytes*0x80 = 16'h0800 at frame_done; macro undefined -> 16'h0000.

Source files
------------

// File: rtl/ov7670_stream_source.sv
// Synthetic OV7670 camera stream: vsync/href/data waveform carrying a luma test pattern.
// Optional per-frame byte checksum on frame_sum when OV_STREAM_CHECKSUM_EN is defined.
module ov7670_stream_source #(
    parameter int H_ACTIVE    = 160,
    parameter int V_ACTIVE    = 120,
    parameter int H_BLANK     = 16,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        continuous,
    input  logic [1:0]  pattern_sel,
    output logic        ov_vsync,
    output logic        ov_href,
    output logic [7:0]  ov_data,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_sum
);

    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int CW       = $clog2(LINE_LEN);
    localparam int VMAX1    = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int VMAX2    = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int VMAX     = (VMAX1 > VMAX2) ? VMAX1 : VMAX2;
    localparam int LW       = $clog2(VMAX + 1);

    localparam logic [CW-1:0] COL_LAST = CW'(LINE_LEN - 1);
    localparam logic [CW-1:0] HREF_END = CW'(2 * H_ACTIVE);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   col_r, col_s;
    logic [LW-1:0]   line_r, line_s, line_last_s;
    logic [1:0]      pattern_r;
    logic            frame_start_s, frame_end_s;
    logic [7:0]      x_s, y_s, luma_s, data_s;
    logic            vsync_s, href_s, busy_s;

    // Last line index of the current vertical region.
    always_comb begin
        line_last_s = {LW{1'b0}};
        case (state_r)
            ST_VSYNC:  line_last_s = LW'(VSYNC_LINES - 1);
            ST_VBACK:  line_last_s = LW'(V_BACK - 1);
            ST_ACTIVE: line_last_s = LW'(V_ACTIVE - 1);
            ST_VFRONT: line_last_s = LW'(V_FRONT - 1);
            default:   line_last_s = {LW{1'b0}};
        endcase
    end

    // Next-state and counter sweep; region changes only at the last column of the last line.
    always_comb begin
        state_s       = state_r;
        col_s         = col_r;
        line_s        = line_r;
        frame_start_s = 1'b0;
        frame_end_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                col_s  = {CW{1'b0}};
                line_s = {LW{1'b0}};
                if (start || continuous) begin
                    state_s       = ST_VSYNC;
                    frame_start_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_VSYNC, ST_VBACK, ST_ACTIVE, ST_VFRONT: begin
                if (col_r == COL_LAST) begin
                    col_s = {CW{1'b0}};
                    if (line_r == line_last_s) begin
                        line_s = {LW{1'b0}};
                        case (state_r)
                            ST_VSYNC:  state_s = ST_VBACK;
                            ST_VBACK:  state_s = ST_ACTIVE;
                            ST_ACTIVE: state_s = ST_VFRONT;
                            ST_VFRONT: begin
                                frame_end_s = 1'b1;
                                if (continuous) begin
                                    state_s       = ST_VSYNC;
                                    frame_start_s = 1'b1;
                                end else begin
                                    state_s = ST_IDLE;
                                end
                            end
                            default:   state_s = ST_IDLE;
                        endcase
                    end else begin
                        line_s = line_r + LW'(1);
                    end
                end else begin
                    col_s = col_r + CW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                col_s   = {CW{1'b0}};
                line_s  = {LW{1'b0}};
            end
        endcase
    end

    // Output decode from the next position so the registered outputs line up with the state.
    always_comb begin
        x_s = 8'(col_s >> 1);
        y_s = 8'(line_s);
        case (pattern_r)
            2'd0:    luma_s = 8'h80;
            2'd1:    luma_s = x_s;
            2'd2:    luma_s = (x_s[3] ^ y_s[3]) ? 8'hFF : 8'h00;
            2'd3:    luma_s = y_s;
            default: luma_s = 8'h80;
        endcase
        vsync_s = (state_s == ST_VSYNC);
        href_s  = (state_s == ST_ACTIVE) && (col_s < HREF_END);
        busy_s  = (state_s != ST_IDLE);
        if (!href_s) begin
            data_s = 8'h00;
        end else if (col_s[0]) begin
            data_s = 8'h80;
        end else begin
            data_s = luma_s;
        end
    end

    // State, counters, latched pattern and registered stream outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            col_r      <= {CW{1'b0}};
            line_r     <= {LW{1'b0}};
            pattern_r  <= 2'd0;
            ov_vsync   <= 1'b0;
            ov_href    <= 1'b0;
            ov_data    <= 8'h00;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_r    <= state_s;
            col_r      <= col_s;
            line_r     <= line_s;
            ov_vsync   <= vsync_s;
            ov_href    <= href_s;
            ov_data    <= data_s;
            busy       <= busy_s;
            frame_done <= frame_end_s;
            if (frame_start_s) begin
                pattern_r <= pattern_sel;
            end
        end
    end

`ifdef OV_STREAM_CHECKSUM_EN
    logic [15:0] acc_r;
    logic [15:0] frame_sum_r;

    // Sum of emitted href-high bytes; published when the frame completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r       <= 16'h0000;
            frame_sum_r <= 16'h0000;
        end else begin
            if (frame_end_s) begin
                frame_sum_r <= acc_r;
            end
            if (frame_start_s) begin
                acc_r <= 16'h0000;
            end else if (ov_href) begin
                acc_r <= acc_r + {8'h00, ov_data};
            end
        end
    end

    assign frame_sum = frame_sum_r;
`else
    assign frame_sum = 16'h0000;
`endif

endmodule
